// File: rtl/i2c_passthru_pkg.sv
// Shared types and helpers for the I2C passthru master arbiter.
package i2c_passthru_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_DISC = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int MULTI_START_DISC   = 0;
    localparam int MULTI_START_LOWEST = 1;

    // $clog2 that never returns less than 1, so derived widths stay legal.
    function automatic int clog2_min1(input int val);
        int r;
        r = $clog2(val);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/i2c_passthru_prio_enc.sv
// Lowest-index priority encoder over the channel activity vector.
// Also flags whether any, or more than one, channel is active.
module i2c_passthru_prio_enc #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] act,
    output logic [IDX_W-1:0]  low_idx,
    output logic              any_act,
    output logic              multi_act
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        low_idx   = '0;
        any_act   = |act;
        multi_act = |(act & (act - NUM_CH'(1)));
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (act[k]) begin
                low_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/i2c_passthru_mstr_arb.sv
// Grants passthru mastership to the first channel that leaves idle, forces
// a disconnect on faults or contested starts, and holds off reconnection
// until all channels have been idle for HOLD_CYC cycles.
//
// state   | meaning
// ST_IDLE | all quiet, waiting for a channel to start
// ST_OWN  | one channel owns the passthru path
// ST_DISC | drivers released after a fault, waiting for all-idle
// ST_HOLD | all-idle qualification before reconnecting
module i2c_passthru_mstr_arb
    import i2c_passthru_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int HOLD_CYC    = 16,
    parameter  int MULTI_START = 0,
    parameter  int CNT_W       = 8,
    localparam int IDX_W       = clog2_min1(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_idle,
    input  logic              i_violation,
    input  logic              i_stuck,
    output logic              o_disconnect,
    output logic              o_mst_vld,
    output logic [NUM_CH-1:0] o_mst_onehot,
    output logic [IDX_W-1:0]  o_mst_idx,
    output logic [CNT_W-1:0]  o_fault_cnt,
    output logic [IDX_W-1:0]  o_fault_idx
);

    localparam int              HCW       = clog2_min1(HOLD_CYC + 1);
    localparam logic [HCW-1:0]  HOLD_LAST = HCW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] FCNT_MAX = '1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] mst_idx;
    logic [HCW-1:0]   hold_cnt;
    logic [NUM_CH-1:0] act;
    logic             all_idle;
    logic [IDX_W-1:0] low_idx;
    logic             any_act, multi_act;
    logic             grant_ld, hold_clr, hold_inc, disc_ent, fault_rec;

    assign act      = ~i_idle;
    assign all_idle = &i_idle;

    i2c_passthru_prio_enc #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_prio_enc (
        .act       (act),
        .low_idx   (low_idx),
        .any_act   (any_act),
        .multi_act (multi_act)
    );

    // Next-state and datapath strobes.
    always_comb begin
        state_nxt = ST_IDLE;
        grant_ld  = 1'b0;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
        disc_ent  = 1'b0;
        fault_rec = 1'b0;
        case (state)
            ST_IDLE: begin
                if (multi_act) begin
                    if (MULTI_START == MULTI_START_LOWEST) begin
                        state_nxt = ST_OWN;
                        grant_ld  = 1'b1;
                    end else begin
                        state_nxt = ST_DISC;
                        disc_ent  = 1'b1;
                    end
                end else if (any_act) begin
                    state_nxt = ST_OWN;
                    grant_ld  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_OWN: begin
                // A fault beats a simultaneous all-idle release.
                if (i_violation || i_stuck) begin
                    state_nxt = ST_DISC;
                    disc_ent  = 1'b1;
                    fault_rec = 1'b1;
                end else if (all_idle) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_OWN;
                end
            end
            ST_DISC: begin
                if (all_idle) begin
                    if (HOLD_CYC == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HOLD;
                        hold_clr  = 1'b1;
                    end
                end else begin
                    state_nxt = ST_DISC;
                end
            end
            ST_HOLD: begin
                if (!all_idle) begin
                    state_nxt = ST_DISC;
                    hold_clr  = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_HOLD;
                    hold_inc  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, grant index, hold timer and fault bookkeeping registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            mst_idx     <= '0;
            hold_cnt    <= '0;
            o_fault_cnt <= '0;
            o_fault_idx <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ld) begin
                mst_idx <= low_idx;
            end
            if (hold_clr) begin
                hold_cnt <= '0;
            end else if (hold_inc) begin
                hold_cnt <= hold_cnt + HCW'(1);
            end
            if (disc_ent && (o_fault_cnt != FCNT_MAX)) begin
                o_fault_cnt <= o_fault_cnt + CNT_W'(1);
            end
            if (fault_rec) begin
                o_fault_idx <= mst_idx;
            end
        end
    end

    // Moore output decode from registered state and grant index.
    always_comb begin
        o_disconnect = 1'b1;
        o_mst_vld    = 1'b0;
        o_mst_onehot = '0;
        o_mst_idx    = '0;
        if (state == ST_OWN) begin
            o_disconnect = 1'b0;
            o_mst_vld    = 1'b1;
            o_mst_onehot = NUM_CH'(1) << mst_idx;
            o_mst_idx    = mst_idx;
        end
    end

endmodule

// File: tb/tb_i2c_passthru_mstr_arb.sv
// Scoreboard bench: dut_d uses MULTI_START=0, HOLD_CYC=16, CNT_W=2;
// dut_l uses MULTI_START=1, HOLD_CYC=0, CNT_W=8.
module tb_i2c_passthru_mstr_arb;

    typedef struct {
        string      name;
        int         cyc;
        int         dut;
        logic       disc;
        logic       vld;
        logic [3:0] oh;
        logic [1:0] idx;
        logic [7:0] fcnt;
        logic [1:0] fidx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_d, viol_d, stuck_d;
    logic [3:0] idle_d;
    logic       disc_d, vld_d;
    logic [3:0] oh_d;
    logic [1:0] idx_d, fcnt_d, fidx_d;

    logic       rst_l, viol_l, stuck_l;
    logic [3:0] idle_l;
    logic       disc_l, vld_l;
    logic [3:0] oh_l;
    logic [1:0] idx_l, fidx_l;
    logic [7:0] fcnt_l;

    i2c_passthru_mstr_arb #(
        .NUM_CH(4), .HOLD_CYC(16), .MULTI_START(0), .CNT_W(2)
    ) dut_d (
        .i_clk(clk), .i_rst(rst_d), .i_idle(idle_d),
        .i_violation(viol_d), .i_stuck(stuck_d),
        .o_disconnect(disc_d), .o_mst_vld(vld_d), .o_mst_onehot(oh_d),
        .o_mst_idx(idx_d), .o_fault_cnt(fcnt_d), .o_fault_idx(fidx_d)
    );

    i2c_passthru_mstr_arb #(
        .NUM_CH(4), .HOLD_CYC(0), .MULTI_START(1), .CNT_W(8)
    ) dut_l (
        .i_clk(clk), .i_rst(rst_l), .i_idle(idle_l),
        .i_violation(viol_l), .i_stuck(stuck_l),
        .o_disconnect(disc_l), .o_mst_vld(vld_l), .o_mst_onehot(oh_l),
        .o_mst_idx(idx_l), .o_fault_cnt(fcnt_l), .o_fault_idx(fidx_l)
    );

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   efc[2];
    int   efi[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int dut, input logic [3:0] idle, input logic v, input logic s);
        if (dut == 0) begin
            idle_d = idle; viol_d = v; stuck_d = s;
        end else begin
            idle_l = idle; viol_l = v; stuck_l = s;
        end
    endtask

    task automatic push(input string name, input int dut, input logic disc, input logic vld,
                        input logic [3:0] oh, input logic [1:0] idx);
        exp_t e;
        e.name = name; e.cyc = cyc; e.dut = dut;
        e.disc = disc; e.vld = vld; e.oh = oh; e.idx = idx;
        e.fcnt = 8'(efc[dut]);
        e.fidx = 2'(efi[dut]);
        sb.push_back(e);
    endtask

    task automatic chk_off(input string name, input int dut);
        push(name, dut, 1'b1, 1'b0, 4'b0000, 2'd0);
    endtask

    task automatic chk_own(input string name, input int dut, input int ch);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        push(name, dut, 1'b0, 1'b1, oh, 2'(ch));
    endtask

    task automatic idle_then_probe(input int dut, input int n, input int ch, input bit grant,
                                   input string name);
        logic [3:0] pv;
        set_in(dut, 4'hF, 1'b0, 1'b0);
        repeat (n) tick();
        pv = 4'hF;
        pv[ch] = 1'b0;
        set_in(dut, pv, 1'b0, 1'b0);
        tick();
        if (grant) chk_own(name, dut, ch);
        else chk_off(name, dut);
    endtask

    // Monitor: pop every expectation due this cycle and compare at negedge.
    initial begin
        exp_t       e;
        logic       a_disc, a_vld;
        logic [3:0] a_oh;
        logic [1:0] a_idx, a_fidx;
        logic [7:0] a_fcnt;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.dut == 0) begin
                    a_disc = disc_d; a_vld = vld_d; a_oh = oh_d; a_idx = idx_d;
                    a_fcnt = {6'b0, fcnt_d}; a_fidx = fidx_d;
                end else begin
                    a_disc = disc_l; a_vld = vld_l; a_oh = oh_l; a_idx = idx_l;
                    a_fcnt = fcnt_l; a_fidx = fidx_l;
                end
                n_chk++;
                if (a_disc === e.disc && a_vld === e.vld && a_oh === e.oh && a_idx === e.idx
                    && a_fcnt === e.fcnt && a_fidx === e.fidx) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d dut=%0d got disc=%b vld=%b oh=%b idx=%0d fcnt=%0d fidx=%0d want disc=%b vld=%b oh=%b idx=%0d fcnt=%0d fidx=%0d",
                             e.name, cyc, e.dut, a_disc, a_vld, a_oh, a_idx, a_fcnt, a_fidx,
                             e.disc, e.vld, e.oh, e.idx, e.fcnt, e.fidx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int sat_seq[5] = '{1, 2, 3, 3, 3};
        efc[0] = 0; efc[1] = 0; efi[0] = 0; efi[1] = 0;
        rst_d = 1'b1; rst_l = 1'b1;
        set_in(0, 4'hF, 1'b0, 1'b0);
        set_in(1, 4'hF, 1'b0, 1'b0);
        repeat (3) tick();
        chk_off("rst_held", 0);
        rst_d = 1'b0; rst_l = 1'b0;
        tick();
        chk_off("rst_rel", 0);
        chk_off("l_rst_rel", 1);
        n_chk++;
        if (disc_d === 1'b1 && vld_d === 1'b0 && fcnt_d === 2'd0) n_pass++;
        else $display("FAIL direct rst_rel disc=%b vld=%b fcnt=%0d", disc_d, vld_d, fcnt_d);

        // Faults are ignored while idle.
        set_in(0, 4'hF, 1'b1, 1'b1); tick(); chk_off("idle_fault_ign", 0);

        set_in(0, 4'b1011, 1'b0, 1'b0); tick(); chk_own("grant_ch2", 0, 2);
        n_chk++;
        if (oh_d === 4'b0100 && idx_d === 2'd2) n_pass++;
        else $display("FAIL direct grant_ch2 oh=%b idx=%0d", oh_d, idx_d);
        set_in(0, 4'b0011, 1'b0, 1'b0); tick(); chk_own("traffic_keeps", 0, 2);
        set_in(0, 4'hF, 1'b0, 1'b0);    tick(); chk_off("release", 0);

        set_in(0, 4'b1001, 1'b0, 1'b0); tick(); efc[0] = 1; chk_off("multi_disc", 0);
        tick(); chk_off("disc_stays", 0);
        idle_then_probe(0, 17, 3, 1'b1, "recover_ch3");

        set_in(0, 4'b0111, 1'b1, 1'b0); tick(); efc[0] = 2; efi[0] = 3; chk_off("viol_ch3", 0);
        n_chk++;
        if (fidx_d === 2'd3 && fcnt_d === 2'd2) n_pass++;
        else $display("FAIL direct viol_ch3 fidx=%0d fcnt=%0d", fidx_d, fcnt_d);
        idle_then_probe(0, 16, 0, 1'b0, "hold_early16");
        idle_then_probe(0, 17, 0, 1'b1, "hold_exact17");

        set_in(0, 4'b1110, 1'b0, 1'b1); tick(); efc[0] = 3; efi[0] = 0; chk_off("stuck_ch0", 0);
        set_in(0, 4'hF, 1'b0, 1'b0);
        repeat (11) tick();
        set_in(0, 4'b1110, 1'b0, 1'b0); tick(); chk_off("hold_bounce", 0);
        idle_then_probe(0, 16, 2, 1'b0, "bounce_early16");
        idle_then_probe(0, 17, 2, 1'b1, "bounce_full17");

        set_in(0, 4'hF, 1'b1, 1'b0); tick(); efi[0] = 2; chk_off("fault_wins", 0);
        idle_then_probe(0, 17, 1, 1'b1, "recover_ch1");

        set_in(0, 4'b1101, 1'b0, 1'b1); rst_d = 1'b1; tick();
        efc[0] = 0; efi[0] = 0; chk_off("rst_with_stuck", 0);
        n_chk++;
        if (vld_d === 1'b0 && fcnt_d === 2'd0) n_pass++;
        else $display("FAIL direct rst_with_stuck vld=%b fcnt=%0d", vld_d, fcnt_d);
        rst_d = 1'b0;
        set_in(0, 4'b1011, 1'b0, 1'b0); tick(); chk_own("post_rst_grant", 0, 2);
        set_in(0, 4'hF, 1'b0, 1'b0);    tick(); chk_off("post_rst_release", 0);

        for (int i = 0; i < 5; i++) begin
            set_in(0, 4'b0110, 1'b0, 1'b0); tick();
            efc[0] = sat_seq[i];
            chk_off($sformatf("sat%0d", i), 0);
            set_in(0, 4'hF, 1'b0, 1'b0);
            repeat (17) tick();
        end

        set_in(1, 4'b1001, 1'b0, 1'b0); tick(); chk_own("l_multi_low", 1, 1);
        n_chk++;
        if (idx_l === 2'd1 && fcnt_l === 8'd0) n_pass++;
        else $display("FAIL direct l_multi_low idx=%0d fcnt=%0d", idx_l, fcnt_l);
        set_in(1, 4'b0001, 1'b0, 1'b0); tick(); chk_own("l_traffic", 1, 1);
        set_in(1, 4'b1101, 1'b1, 1'b0); tick(); efc[1] = 1; efi[1] = 1; chk_off("l_viol", 1);
        set_in(1, 4'hF, 1'b0, 1'b0);    tick(); chk_off("l_disc_exit", 1);
        set_in(1, 4'b0111, 1'b0, 1'b0); tick(); chk_own("l_hold0_grant", 1, 3);
        set_in(1, 4'hF, 1'b0, 1'b0);    tick(); chk_off("l_release", 1);
        set_in(1, 4'b0100, 1'b0, 1'b1); tick(); chk_own("l_multi3", 1, 0);

        repeat (2) tick();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_chk++;
            $display("FAIL %s never compared (due cyc=%0d, now %0d)", e.name, e.cyc, cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
